// File: rtl/melody_player_if.sv
// Control/playback bundle between the sequencer control logic and the melody player.
interface melody_player_if #(
  parameter int unsigned NOTE_W = 2,
  parameter int unsigned ADDR_W = 3
) ();
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic              busy;
  logic [ADDR_W-1:0] addr_out;
  logic              done;

  modport master (
    output start, stop, loop_en,
    input  note, note_valid, busy, addr_out, done
  );

  modport slave (
    input  start, stop, loop_en,
    output note, note_valid, busy, addr_out, done
  );
endinterface

// File: rtl/melody_player.sv
// Steps through a DEPTH-entry {dur, note} table, holding each note for dur beats.
// Table image comes from INIT_TABLE (entry 0 in the LSBs) unless USE_DEFAULT selects the built-in tune.
module melody_player #(
  parameter int unsigned NOTE_W         = 2,
  parameter int unsigned DUR_W          = 2,
  parameter int unsigned DEPTH          = 7,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned TICKS_PER_BEAT = 25000000,
  parameter bit          USE_DEFAULT    = 1'b1,
  parameter logic [DEPTH*(NOTE_W+DUR_W)-1:0] INIT_TABLE = '0
) (
  input logic            clk,
  input logic            reset,
  melody_player_if.slave bus
);
  localparam int unsigned WORD_W = NOTE_W + DUR_W;
  localparam int unsigned TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  // Built-in tune 3,2,1,2,3,3,3 with beats 1,1,1,1,1,1,2, repeated if DEPTH > 7.
  function automatic logic [DEPTH*WORD_W-1:0] build_table();
    logic [DEPTH*WORD_W-1:0] t;
    logic [NOTE_W-1:0]       n;
    logic [DUR_W-1:0]        d;
    t = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (i % 7)
        1, 3:    n = NOTE_W'(2);
        2:       n = NOTE_W'(1);
        default: n = NOTE_W'(3);
      endcase
      d = ((i % 7) == 6) ? DUR_W'(2) : DUR_W'(1);
      t[i*WORD_W +: WORD_W] = {d, n};
    end
    return t;
  endfunction

  localparam logic [DEPTH*WORD_W-1:0] TABLE = USE_DEFAULT ? build_table() : INIT_TABLE;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [DUR_W-1:0]  beat;
  logic [WORD_W-1:0] rd_word_c;
  logic [NOTE_W-1:0] rd_note_c;
  logic [DUR_W-1:0]  rd_dur_c;

  // Table lookup; only the DEPTH real entries are decoded.
  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.addr_out == ADDR_W'(i)) rd_word_c = TABLE[i*WORD_W +: WORD_W];
    end
  end

  assign rd_note_c = rd_word_c[NOTE_W-1:0];
  assign rd_dur_c  = rd_word_c[WORD_W-1:NOTE_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tick           <= '0;
      beat           <= '0;
      bus.note       <= '0;
      bus.note_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.addr_out   <= '0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state        <= FETCH;
            bus.busy     <= 1'b1;
            bus.addr_out <= '0;
          end
        end
        FETCH: begin
          if (bus.stop) begin
            state          <= IDLE;
            tick           <= '0;
            beat           <= '0;
            bus.note_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.addr_out   <= '0;
          end else begin
            state          <= PLAY;
            bus.note       <= rd_note_c;
            beat           <= (rd_dur_c == '0) ? DUR_W'(1) : rd_dur_c;
            tick           <= '0;
            bus.note_valid <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state          <= IDLE;
            tick           <= '0;
            beat           <= '0;
            bus.note_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.addr_out   <= '0;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            if (beat == DUR_W'(1)) begin
              // Last tick of the last beat: advance, wrap, or finish.
              bus.note_valid <= 1'b0;
              if (bus.addr_out < ADDR_LAST) begin
                bus.addr_out <= bus.addr_out + ADDR_W'(1);
                state        <= FETCH;
              end else if (bus.loop_en) begin
                bus.addr_out <= '0;
                state        <= FETCH;
              end else begin
                bus.addr_out <= '0;
                bus.busy     <= 1'b0;
                bus.done     <= 1'b1;
                state        <= IDLE;
              end
            end else begin
              beat <= beat - DUR_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: directed vector table, play-through sequences and a random run against a reference model.
module tb_melody_player;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  melody_player_if #(.NOTE_W(2), .ADDR_W(3)) bus  ();
  melody_player_if #(.NOTE_W(2), .ADDR_W(1)) bus0 ();
  melody_player_if #(.NOTE_W(2), .ADDR_W(1)) bus1 ();

  melody_player #(.TICKS_PER_BEAT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Two entries: {dur 0, note 2}, {dur 1, note 1}.
  melody_player #(.DEPTH(2), .ADDR_W(1), .TICKS_PER_BEAT(T), .USE_DEFAULT(1'b0),
                  .INIT_TABLE(8'h52)) dut_d0 (.clk(clk), .reset(reset), .bus(bus0));

  // Single entry: {dur 3, note 1}.
  melody_player #(.DEPTH(1), .ADDR_W(1), .TICKS_PER_BEAT(T), .USE_DEFAULT(1'b0),
                  .INIT_TABLE(4'hD)) dut_d1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  int mn[7] = '{3, 2, 1, 2, 3, 3, 3};
  int md[7] = '{1, 1, 1, 1, 1, 1, 2};
  int main_notes[$] = '{3, 2, 1, 2, 3, 3, 3};
  int main_lens[$]  = '{4, 4, 4, 4, 4, 4, 8};
  int d0_notes[$]   = '{2, 1};
  int d0_lens[$]    = '{4, 4};
  int d1_notes[$]   = '{1};
  int d1_lens[$]    = '{12};

  // Reference model: playback position as (entry index, cycle offset inside the entry).
  int m_play = 0, m_idx = 0, m_off = 0, m_note = 0, m_done = 0;

  logic [7:0] rec_m [256];
  logic [5:0] rec_0 [256];
  logic [5:0] rec_1 [256];
  int rec_n = 0;

  int tr_nv[$], tr_note[$], tr_busy[$], tr_addr[$], tr_done[$];

  typedef struct {
    logic  rst;
    logic  start;
    logic  stop;
    int    exp;
    string name;
  } vec_t;
  vec_t vecs[13];

  function automatic int pk(int note, int nv, int busy, int addr, int done);
    return note * 64 + nv * 32 + busy * 16 + addr * 2 + done;
  endfunction

  function automatic int pack_main();
    return int'({bus.note, bus.note_valid, bus.busy, bus.addr_out, bus.done});
  endfunction

  task automatic model_step();
    int dur;
    if (reset) begin
      m_play = 0; m_idx = 0; m_off = 0; m_note = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_play == 0) begin
        if (bus.start && !bus.stop) begin
          m_play = 1; m_idx = 0; m_off = 0;
        end
      end else if (bus.stop) begin
        m_play = 0; m_idx = 0;
      end else begin
        dur = (md[m_idx] == 0) ? 1 : md[m_idx];
        if (m_off == 0) m_note = mn[m_idx];
        if (m_off + 1 < 1 + dur * int'(T)) m_off++;
        else if (m_idx < 6) begin m_idx++; m_off = 0; end
        else if (bus.loop_en) begin m_idx = 0; m_off = 0; end
        else begin m_play = 0; m_idx = 0; m_done = 1; end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, then sample and compare 1 time unit later.
  task automatic tick();
    int exp;
    @(posedge clk);
    model_step();
    #1;
    exp = pk(m_note, (m_play != 0 && m_off > 0) ? 1 : 0, m_play, m_idx, m_done);
    check($sformatf("model@%0t", $time), pack_main(), exp);
    if (rec_n < 256) begin
      rec_m[rec_n] = {bus.note, bus.note_valid, bus.busy, bus.addr_out, bus.done};
      rec_0[rec_n] = {bus0.note, bus0.note_valid, bus0.busy, bus0.addr_out, bus0.done};
      rec_1[rec_n] = {bus1.note, bus1.note_valid, bus1.busy, bus1.addr_out, bus1.done};
      rec_n++;
    end
  endtask

  task automatic load(input int which, input int n);
    logic [7:0] v;
    logic [5:0] w;
    tr_nv.delete(); tr_note.delete(); tr_busy.delete(); tr_addr.delete(); tr_done.delete();
    for (int i = 0; i < n; i++) begin
      if (which == 0) begin
        v = rec_m[i];
        tr_note.push_back(int'(v[7:6])); tr_nv.push_back(int'(v[5]));
        tr_busy.push_back(int'(v[4]));   tr_addr.push_back(int'(v[3:1]));
        tr_done.push_back(int'(v[0]));
      end else begin
        w = (which == 1) ? rec_0[i] : rec_1[i];
        tr_note.push_back(int'(w[5:4])); tr_nv.push_back(int'(w[3]));
        tr_busy.push_back(int'(w[2]));   tr_addr.push_back(int'(w[1]));
        tr_done.push_back(int'(w[0]));
      end
    end
  endtask

  // Note runs must start 1 cycle after E0 and follow each other with exactly one low cycle.
  task automatic check_runs(input string name, input int n, input int notes[$], input int lens[$],
                            input int reps, input int done_at, input int max_addr);
    int s, len, act, dcnt, dfirst, amax, j;
    s = 1;
    for (int r = 0; r < reps * notes.size(); r++) begin
      j = r % notes.size();
      len = 0;
      while (s + len < n && tr_nv[s + len] == 1) len++;
      act = ((s < n && tr_nv[s - 1] == 0) ? 1000 : 0) + ((s < n) ? tr_note[s] * 100 : 0) + len;
      check($sformatf("%s_run%0d", name, r), act, 1000 + notes[j] * 100 + lens[j]);
      s += lens[j] + 1;
    end
    dcnt = 0; dfirst = -1; amax = 0;
    for (int i = 0; i < n; i++) begin
      if (tr_done[i] == 1) begin dcnt++; if (dfirst < 0) dfirst = i; end
      if (tr_addr[i] > amax) amax = tr_addr[i];
    end
    check({name, "_done_count"}, dcnt, 1);
    check({name, "_done_at"}, dfirst, done_at);
    check({name, "_busy_fall"}, tr_busy[done_at - 1] * 10 + tr_busy[done_at], 10);
    check({name, "_max_addr"}, amax, max_addr);
  endtask

  task automatic single_play(input string name, input bit poke, input bit with_small);
    bus.start = 1'b1;
    bus0.start = with_small; bus1.start = with_small;
    rec_n = 0;
    tick();
    bus.start = 1'b0; bus0.start = 1'b0; bus1.start = 1'b0;
    for (int k = 1; k < 46; k++) begin
      bus.start = poke && (k == 10);
      tick();
    end
    bus.start = 1'b0;
    load(0, 46);
    check_runs(name, 46, main_notes, main_lens, 1, 39, 6);
    if (with_small) begin
      load(1, 46);
      check_runs({name, "_dur0"}, 46, d0_notes, d0_lens, 1, 10, 1);
      load(2, 46);
      check_runs({name, "_depth1"}, 46, d1_notes, d1_lens, 1, 13, 0);
    end
  endtask

  initial begin
    int dcnt;
    reset = 1'b1;
    bus.start = 1'b0;  bus.stop = 1'b0;  bus.loop_en = 1'b0;
    bus0.start = 1'b0; bus0.stop = 1'b0; bus0.loop_en = 1'b0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.loop_en = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 0), "reset"};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0), "idle"};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, pk(0, 0, 0, 0, 0), "start_stop_idle"};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, pk(0, 0, 1, 0, 0), "fetch0"};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, pk(3, 1, 1, 0, 0), "play0_t0"};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, pk(3, 1, 1, 0, 0), "start_busy"};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, pk(3, 1, 1, 0, 0), "play0_t2"};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, pk(3, 1, 1, 0, 0), "play0_t3"};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, pk(3, 0, 1, 1, 0), "fetch1_gap"};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, pk(2, 1, 1, 1, 0), "play1"};
    vecs[10] = '{1'b0, 1'b0, 1'b1, pk(2, 0, 0, 0, 0), "stop_play"};
    vecs[11] = '{1'b0, 1'b0, 1'b0, pk(2, 0, 0, 0, 0), "idle_note_hold"};
    vecs[12] = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 0), "reset_again"};

    foreach (vecs[i]) begin
      reset = vecs[i].rst; bus.start = vecs[i].start; bus.stop = vecs[i].stop;
      tick();
      check({"vec_", vecs[i].name}, pack_main(), vecs[i].exp);
    end
    reset = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    tick(); tick();

    single_play("single", 1'b1, 1'b1);
    tick(); tick();

    // Loop for one pass, then drop loop_en part way through the second.
    bus.loop_en = 1'b1;
    bus.start = 1'b1; rec_n = 0; tick(); bus.start = 1'b0;
    for (int k = 1; k < 86; k++) begin
      if (k == 50) bus.loop_en = 1'b0;
      tick();
    end
    check("loop_wrap", int'(rec_m[39]), pk(3, 0, 1, 0, 0));
    check("loop_replay", int'(rec_m[40]), pk(3, 1, 1, 0, 0));
    load(0, 86);
    check_runs("loop", 86, main_notes, main_lens, 2, 78, 6);
    tick(); tick();

    // Stop during entry 2, then restart from entry 0.
    bus.start = 1'b1; rec_n = 0; tick(); bus.start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      bus.stop = (k == 13);
      tick();
    end
    bus.stop = 1'b0;
    check("stop_before", int'(rec_m[12]), pk(1, 1, 1, 2, 0));
    check("stop_after", int'(rec_m[13]), pk(1, 0, 0, 0, 0));
    tick(); tick();
    bus.start = 1'b1; rec_n = 0; tick(); bus.start = 1'b0; tick();
    check("restart_fetch", int'(rec_m[0]), pk(1, 0, 1, 0, 0));
    check("restart_play", int'(rec_m[1]), pk(3, 1, 1, 0, 0));
    bus.stop = 1'b1; tick(); bus.stop = 1'b0; tick();

    // Reset during entry 4, then a full replay.
    bus.start = 1'b1; rec_n = 0; tick(); bus.start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      reset = (k == 22);
      tick();
    end
    reset = 1'b0;
    check("reset_entry4", int'(rec_m[21]), pk(3, 1, 1, 4, 0));
    check("reset_mid", int'(rec_m[22]), 0);
    dcnt = 0;
    for (int i = 0; i <= 22; i++) dcnt += int'(rec_m[i][0]);
    check("reset_no_done", dcnt, 0);
    tick();
    single_play("replay", 1'b0, 1'b0);

    // Random control traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(799) == 0);
      bus.start = ($urandom_range(3) == 0);
      bus.stop = ($urandom_range(99) == 0);
      if ($urandom_range(49) == 0) bus.loop_en = ~bus.loop_en;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
